qe_m_checker: RTL and testbench

Passive, latency-independent result checker that sits alongside the QE_M quadratic/MAC unit in block-level and system benches. It observes the operand side of QE_M, computes the expected 16-bit result for every result-producing transaction, queues it in an expected-value FIFO, and compares it against QE_M's `valid_out`/`result` stream. It reports pass/fail counts and protocol errors, and never drives QE_M.

---
 rtl/qe_m_checker.sv | 200 ++++++++++++++++++++
 tb/tb_qe_m_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qe_m_checker.sv
// Passive scoreboard for the QE_M quadratic/MAC unit: predicts each result from the
// operand stream, queues it, and compares against the unit's result stream.
module qe_m_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [7:0]               in_c,
    input  logic [7:0]               in_x,
    input  logic                     mode,
    input  logic                     valid_in,
    input  logic                     last_input,
    input  logic                     valid_out,
    input  logic [15:0]              result,
    output logic [15:0]              pass_cnt,
    output logic [15:0]              fail_cnt,
    output logic                     mismatch,
    output logic [15:0]              exp_value,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow_err,
    output logic                     underflow_err,
    output logic                     timeout_err,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   L_FULL   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] L_TO     = TW'(TIMEOUT);
    localparam logic [TW-1:0] L_TO_M1  = TW'(TIMEOUT - 1);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic [15:0]   r_acc;
    logic          r_macOpen;
    logic [TW-1:0] r_toCnt;
    logic [15:0]   r_passCnt;
    logic [15:0]   r_failCnt;
    logic          r_mismatch;
    logic [15:0]   r_expValue;
    logic          r_overflowErr;
    logic          r_underflowErr;
    logic          r_timeoutErr;
    logic          r_protoErr;

    logic [15:0]   w_a16;
    logic [15:0]   w_b16;
    logic [15:0]   w_c16;
    logic [15:0]   w_x16;
    logic [15:0]   w_quadVal;
    logic [15:0]   w_macSum;
    logic          w_quadTxn;
    logic          w_macTxn;
    logic          w_push;
    logic [15:0]   w_pushVal;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_overflow;
    logic [15:0]   w_head;

    // All arithmetic is carried in 16 bits, which is exactly modulo-2^16 truncation.
    assign w_a16     = {8'd0, in_a};
    assign w_b16     = {8'd0, in_b};
    assign w_c16     = {8'd0, in_c};
    assign w_x16     = {8'd0, in_x};
    assign w_quadVal = w_a16 * w_x16 * w_x16 + w_b16 * w_x16 + w_c16;
    assign w_macSum  = r_acc + w_a16 * w_x16;

    assign w_quadTxn  = valid_in & ~mode;
    assign w_macTxn   = valid_in & mode;
    assign w_push     = w_quadTxn | (w_macTxn & last_input);
    assign w_pushVal  = w_quadTxn ? w_quadVal : w_macSum;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == L_FULL);
    assign w_pop      = valid_out & ~w_empty;
    assign w_wr       = w_push & (~w_full | w_pop);
    assign w_overflow = w_push & w_full & ~w_pop;
    assign w_head     = r_mem[r_rdPtr];

    // Storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= w_pushVal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A MAC sequence is open once a non-last beat is seen; the last beat closes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_macOpen <= 1'b0;
        end else if (w_macTxn) begin
            if (last_input) begin
                r_acc     <= '0;
                r_macOpen <= 1'b0;
            end else begin
                r_acc     <= w_macSum;
                r_macOpen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_passCnt  <= '0;
            r_failCnt  <= '0;
            r_mismatch <= 1'b0;
            r_expValue <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_pop) begin
                r_expValue <= w_head;
                if (w_head == result) begin
                    if (r_passCnt != 16'hFFFF) begin
                        r_passCnt <= r_passCnt + 16'd1;
                    end
                end else begin
                    r_mismatch <= 1'b1;
                    if (r_failCnt != 16'hFFFF) begin
                        r_failCnt <= r_failCnt + 16'd1;
                    end
                end
            end
        end
    end

    // The wait counter saturates at TIMEOUT so a stalled FIFO never wraps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_toCnt      <= '0;
            r_timeoutErr <= 1'b0;
        end else if (w_empty || valid_out) begin
            r_toCnt <= '0;
        end else begin
            if (r_toCnt != L_TO) begin
                r_toCnt <= r_toCnt + 1'b1;
            end
            if (r_toCnt >= L_TO_M1) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflowErr  <= 1'b0;
            r_underflowErr <= 1'b0;
            r_protoErr     <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_overflowErr <= 1'b1;
            end
            if (valid_out && w_empty) begin
                r_underflowErr <= 1'b1;
            end
            if (w_quadTxn && ((r_acc != '0) || r_macOpen)) begin
                r_protoErr <= 1'b1;
            end
        end
    end

    assign pass_cnt      = r_passCnt;
    assign fail_cnt      = r_failCnt;
    assign mismatch      = r_mismatch;
    assign exp_value     = r_expValue;
    assign pending       = r_count;
    assign overflow_err  = r_overflowErr;
    assign underflow_err = r_underflowErr;
    assign timeout_err   = r_timeoutErr;
    assign proto_err     = r_protoErr;

endmodule

// File: tb/tb_qe_m_checker.sv
// Directed bench for qe_m_checker; each scenario task drives QE_M-style traffic and
// compares the checker's outputs against hand-computed values.
module tb_qe_m_checker;

    logic        clk;
    logic        reset;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  in_c;
    logic [7:0]  in_x;
    logic        mode;
    logic        valid_in;
    logic        last_input;
    logic        valid_out;
    logic [15:0] result;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        mismatch;
    logic [15:0] exp_value;
    logic [3:0]  pending;
    logic        overflow_err;
    logic        underflow_err;
    logic        timeout_err;
    logic        proto_err;

    int checks = 0;
    int passes = 0;

    qe_m_checker #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_x(in_x),
        .mode(mode), .valid_in(valid_in), .last_input(last_input),
        .valid_out(valid_out), .result(result),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch(mismatch),
        .exp_value(exp_value), .pending(pending),
        .overflow_err(overflow_err), .underflow_err(underflow_err),
        .timeout_err(timeout_err), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        valid_in = 0; valid_out = 0; last_input = 0; mode = 0; result = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic pushQuad(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
        in_a = a; in_b = b; in_c = c; in_x = x; mode = 0; last_input = 0; valid_in = 1;
        tick();
        valid_in = 0;
    endtask

    task automatic macBeat(input logic [7:0] a, input logic [7:0] x, input logic last);
        in_a = a; in_x = x; mode = 1; last_input = last; valid_in = 1;
        tick();
        valid_in = 0; last_input = 0; mode = 0;
    endtask

    task automatic popResult(input logic [15:0] r);
        result = r; valid_out = 1;
        tick();
        valid_out = 0;
    endtask

    task automatic test_reset();
        reset = 1; valid_in = 0; valid_out = 0; last_input = 0; mode = 0; result = 0;
        in_a = 0; in_b = 0; in_c = 0; in_x = 0;
        #2;
        checks++;
        if ({pass_cnt, fail_cnt, exp_value, pending, mismatch, overflow_err, underflow_err, timeout_err, proto_err} !== '0)
            $display("[TB] FAIL reset_state got pass=%0d fail=%0d exp=%0d pend=%0d", pass_cnt, fail_cnt, exp_value, pending);
        else passes++;
        tick();
        reset = 0;
    endtask

    task automatic test_quadratic();
        doReset();
        pushQuad(100, 5, 25, 8);
        checks++;
        if (pending !== 4'd1) $display("[TB] FAIL quad_pending got %0d want 1", pending); else passes++;
        popResult(16'd6465);
        checks++;
        if (pass_cnt !== 16'd1) $display("[TB] FAIL quad_pass_cnt got %0d want 1", pass_cnt); else passes++;
        checks++;
        if (exp_value !== 16'd6465) $display("[TB] FAIL quad_exp_value got %0d want 6465", exp_value); else passes++;
        checks++;
        if (pending !== 4'd0) $display("[TB] FAIL quad_pending_drain got %0d want 0", pending); else passes++;
    endtask

    task automatic test_invalid_then_valid();
        doReset();
        in_a = 4; in_b = 7; in_c = 11; in_x = 1; mode = 0; valid_in = 0;
        tick();
        pushQuad(100, 5, 3, 0);
        checks++;
        if (pending !== 4'd1) $display("[TB] FAIL inval_pending got %0d want 1", pending); else passes++;
        popResult(16'd3);
        checks++;
        if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0)
            $display("[TB] FAIL inval_pass got pass=%0d fail=%0d want 1/0", pass_cnt, fail_cnt);
        else passes++;
        in_a = 4; in_b = 7; in_c = 11; in_x = 1; valid_in = 0;
        tick();
        pushQuad(100, 5, 3, 0);
        popResult(16'd22);
        checks++;
        if (mismatch !== 1'b1 || fail_cnt !== 16'd1)
            $display("[TB] FAIL mismatch_pulse got mm=%0b fail=%0d want 1/1", mismatch, fail_cnt);
        else passes++;
        checks++;
        if (exp_value !== 16'd3) $display("[TB] FAIL mismatch_exp got %0d want 3", exp_value); else passes++;
        tick();
        checks++;
        if (mismatch !== 1'b0 || pass_cnt !== 16'd1)
            $display("[TB] FAIL mismatch_one_cycle got mm=%0b pass=%0d want 0/1", mismatch, pass_cnt);
        else passes++;
    endtask

    task automatic test_mac();
        doReset();
        macBeat(100, 8, 0);
        in_a = 20; in_x = 3; mode = 1; valid_in = 0;
        tick();
        checks++;
        if (pending !== 4'd0) $display("[TB] FAIL mac_no_push got %0d want 0", pending); else passes++;
        macBeat(1, 2, 1);
        checks++;
        if (pending !== 4'd1) $display("[TB] FAIL mac_push got %0d want 1", pending); else passes++;
        popResult(16'd802);
        checks++;
        if (pass_cnt !== 16'd1 || exp_value !== 16'd802)
            $display("[TB] FAIL mac_802 got pass=%0d exp=%0d want 1/802", pass_cnt, exp_value);
        else passes++;
        macBeat(3, 3, 1);
        popResult(16'd9);
        checks++;
        if (pass_cnt !== 16'd2 || exp_value !== 16'd9 || proto_err !== 1'b0)
            $display("[TB] FAIL mac_second got pass=%0d exp=%0d proto=%0b want 2/9/0", pass_cnt, exp_value, proto_err);
        else passes++;
    endtask

    task automatic test_proto();
        doReset();
        macBeat(2, 3, 0);
        pushQuad(1, 1, 1, 2);
        checks++;
        if (proto_err !== 1'b1) $display("[TB] FAIL proto_err got %0b want 1", proto_err); else passes++;
        macBeat(1, 4, 1);
        checks++;
        if (pending !== 4'd2) $display("[TB] FAIL proto_pending got %0d want 2", pending); else passes++;
        result = 16'd7; valid_out = 1;
        tick();
        result = 16'd10;
        tick();
        valid_out = 0;
        checks++;
        if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0 || exp_value !== 16'd10)
            $display("[TB] FAIL proto_values got pass=%0d fail=%0d exp=%0d want 2/0/10", pass_cnt, fail_cnt, exp_value);
        else passes++;
    endtask

    task automatic test_overflow_underflow();
        doReset();
        for (int i = 0; i < 9; i++) pushQuad(0, 0, 8'(i), 0);
        checks++;
        if (overflow_err !== 1'b1 || pending !== 4'd8)
            $display("[TB] FAIL overflow got ovf=%0b pend=%0d want 1/8", overflow_err, pending);
        else passes++;
        doReset();
        checks++;
        if (underflow_err !== 1'b0 || overflow_err !== 1'b0)
            $display("[TB] FAIL sticky_cleared got unf=%0b ovf=%0b want 0/0", underflow_err, overflow_err);
        else passes++;
        popResult(16'd0);
        checks++;
        if (underflow_err !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || pending !== 4'd0)
            $display("[TB] FAIL underflow got unf=%0b pass=%0d fail=%0d pend=%0d", underflow_err, pass_cnt, fail_cnt, pending);
        else passes++;
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 1; i <= 8; i++) pushQuad(0, 0, 8'(i), 0);
        in_a = 0; in_b = 0; in_c = 99; in_x = 0; mode = 0; valid_in = 1;
        result = 16'd1; valid_out = 1;
        tick();
        valid_in = 0;
        checks++;
        if (pending !== 4'd8 || overflow_err !== 1'b0 || exp_value !== 16'd1)
            $display("[TB] FAIL full_push_pop got pend=%0d ovf=%0b exp=%0d want 8/0/1", pending, overflow_err, exp_value);
        else passes++;
        for (int i = 2; i <= 8; i++) begin
            result = 16'(i);
            tick();
        end
        result = 16'd99;
        tick();
        valid_out = 0;
        checks++;
        if (pass_cnt !== 16'd9 || fail_cnt !== 16'd0 || pending !== 4'd0 || exp_value !== 16'd99)
            $display("[TB] FAIL back_to_back got pass=%0d fail=%0d pend=%0d exp=%0d", pass_cnt, fail_cnt, pending, exp_value);
        else passes++;
    endtask

    task automatic test_timeout();
        doReset();
        pushQuad(0, 0, 5, 0);
        repeat (63) tick();
        checks++;
        if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_early got %0b want 0", timeout_err); else passes++;
        tick();
        checks++;
        if (timeout_err !== 1'b1 || pending !== 4'd1)
            $display("[TB] FAIL timeout_64 got to=%0b pend=%0d want 1/1", timeout_err, pending);
        else passes++;
        doReset();
        pushQuad(0, 0, 5, 0);
        repeat (62) tick();
        popResult(16'd5);
        repeat (70) tick();
        checks++;
        if (timeout_err !== 1'b0 || pass_cnt !== 16'd1)
            $display("[TB] FAIL timeout_avoid got to=%0b pass=%0d want 0/1", timeout_err, pass_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid();
        doReset();
        pushQuad(1, 1, 1, 1);
        pushQuad(2, 2, 2, 2);
        popResult(16'd0);
        pushQuad(3, 3, 3, 3);
        pushQuad(4, 4, 4, 4);
        macBeat(50, 50, 0);
        in_a = 7; in_x = 7; mode = 1; valid_in = 1;
        #3;
        checks++;
        if (pending !== 4'd3 || fail_cnt !== 16'd1)
            $display("[TB] FAIL mid_setup got pend=%0d fail=%0d want 3/1", pending, fail_cnt);
        else passes++;
        reset = 1;
        #1;
        checks++;
        if ({pass_cnt, fail_cnt, exp_value, pending, mismatch, overflow_err, underflow_err, timeout_err, proto_err} !== '0)
            $display("[TB] FAIL mid_reset got pend=%0d fail=%0d exp=%0d", pending, fail_cnt, exp_value);
        else passes++;
        valid_in = 0; mode = 0;
        tick();
        reset = 0;
        macBeat(2, 5, 1);
        popResult(16'd10);
        checks++;
        if (pass_cnt !== 16'd1 || exp_value !== 16'd10 || fail_cnt !== 16'd0)
            $display("[TB] FAIL mid_after got pass=%0d exp=%0d fail=%0d want 1/10/0", pass_cnt, exp_value, fail_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_quadratic();
        test_invalid_then_valid();
        test_mac();
        test_proto();
        test_overflow_underflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
